// File: rtl/mega_regs_mp.sv
// Byte/pair register file with two read ports, a primary write port, a pointer
// write-back port and a post-reset clear sequence that zeroes one pair per cycle.
module mega_regs_mp #(
  parameter int    REG_COUNT          = 32,
  parameter string REGISTERED_OUTPUTS = "FALSE",
  parameter string BYPASS             = "TRUE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1a,
  input  logic        rs1m,
  output logic [15:0] rs1,
  input  logic [4:0]  rs2a,
  input  logic        rs2m,
  output logic [15:0] rs2,
  input  logic [4:0]  rda,
  input  logic [15:0] rd,
  input  logic        rdw,
  input  logic        rdm,
  input  logic [1:0]  pa,
  input  logic        pw,
  input  logic [15:0] pd,
  output logic [15:0] ptr,
  output logic        ready
);

  localparam bit RegOut = (REGISTERED_OUTPUTS == "TRUE");
  localparam bit FwdEn  = RegOut || (BYPASS == "TRUE");
  localparam int Base   = 32 - REG_COUNT;
  localparam int Pairs  = REG_COUNT / 2;
  localparam int CntW   = $clog2(Pairs);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              clearing;
  logic [3:0]        clrPair;
  logic [31:0]       wrEn;
  logic [31:0][7:0]  wrData;
  logic [31:0][7:0]  fwdView;
  wire  [31:0][7:0]  regView;
  logic [15:0]       rs1_d, rs2_d, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Pairs - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clearing = (state_q == CLEAR);
    ready_d  = (state_d == RUN);
  end

  assign clrPair = 4'(Base / 2) + 4'(cnt_q);

  // Per-byte write decode; rd is checked before the pointer port so it wins collisions.
  always_comb begin
    wrEn   = '0;
    wrData = '0;
    for (int i = 0; i < 32; i++) begin
      if (i >= Base) begin
        if (clearing) begin
          if (4'(i / 2) == clrPair) wrEn[i] = 1'b1;
        end else if (rdw && (rdm ? (rda[3:0] == 4'(i / 2)) : (rda == 5'(i)))) begin
          wrEn[i]   = 1'b1;
          wrData[i] = (rdm && (i % 2 == 1)) ? rd[15:8] : rd[7:0];
        end else if (pw && (pa != 2'd0) && ({2'b11, pa} == 4'(i / 2))) begin
          wrEn[i]   = 1'b1;
          wrData[i] = (i % 2 == 1) ? pd[15:8] : pd[7:0];
        end
      end
    end
  end

  for (genvar g = 0; g < 32; g++) begin : gReg
    if (g >= Base) begin : gImpl
      logic [7:0] byte_q;
      always_ff @(posedge clk) begin
        if (wrEn[g]) byte_q <= wrData[g];
      end
      assign regView[g] = byte_q;
    end else begin : gNone
      assign regView[g] = 8'h00;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      fwdView[i] = (FwdEn && wrEn[i]) ? wrData[i] : regView[i];
    end
  end

  function automatic logic [15:0] selectRead(input logic [31:0][7:0] view,
                                             input logic [4:0] a, input logic m);
    if (m) return {view[{a[3:0], 1'b1}], view[{a[3:0], 1'b0}]};
    return {8'h00, view[a]};
  endfunction

  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    ptr_d = '0;
    if (!clearing) begin
      rs1_d = selectRead(fwdView, rs1a, rs1m);
      rs2_d = selectRead(fwdView, rs2a, rs2m);
      if (pa != 2'd0) ptr_d = selectRead(fwdView, {1'b0, 2'b11, pa}, 1'b1);
    end
  end

  if (RegOut) begin : gOutReg
    logic [15:0] rs1_q, rs2_q, ptr_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rs1_q <= '0;
        rs2_q <= '0;
        ptr_q <= '0;
      end else begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        ptr_q <= ptr_d;
      end
    end
    assign rs1 = rs1_q;
    assign rs2 = rs2_q;
    assign ptr = ptr_q;
  end else begin : gOutComb
    assign rs1 = rs1_d;
    assign rs2 = rs2_d;
    assign ptr = ptr_d;
  end

  assign ready = ready_q;

endmodule

// File: doc/mega_regs_mp.md
MEGA_REGS_MP -- requirements
Module: mega_regs_mp

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, meaning the number of implemented byte registers; legal values are 16 and 32.
REQ-002 SHALL have parameter REGISTERED_OUTPUTS, default "FALSE", meaning rs1/rs2/ptr are registered ("TRUE") or combinational ("FALSE").
REQ-003 SHALL have parameter BYPASS, default "TRUE", meaning same-cycle write-to-read forwarding is enabled when REGISTERED_OUTPUTS = "FALSE".
REQ-004 SHALL have port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: rs1a  in  5  read port 1 address (byte index or pair index).
REQ-007 SHALL have port: rs1m  in  1  read port 1 mode (0 = byte, 1 = pair).
REQ-008 SHALL have port: rs1  out  16  read port 1 data.
REQ-009 SHALL have ports rs2a (in, 5), rs2m (in, 1) and rs2 (out, 16), identical in meaning to the port-1 signals.
REQ-010 SHALL have port: rda  in  5  primary write address.
REQ-011 SHALL have port: rd  in  16  primary write data.
REQ-012 SHALL have port: rdw  in  1  primary write enable.
REQ-013 SHALL have port: rdm  in  1  primary write mode (0 = byte, 1 = pair).
REQ-014 SHALL have port: pa  in  2  pointer select (0 = none, 1 = X r27:r26, 2 = Y r29:r28, 3 = Z r31:r30).
REQ-015 SHALL have port: pw  in  1  pointer write enable (post-increment/pre-decrement write-back).
REQ-016 SHALL have port: pd  in  16  pointer write data.
REQ-017 SHALL have port: ptr  out  16  current value of the selected pointer.
REQ-018 SHALL have port: ready  out  1  clear sequence is complete and the register file is usable.

Function
REQ-019 Byte mode SHALL address register rNN = addr[4:0] and SHALL return {8'h00, rNN}.
REQ-020 Pair mode SHALL address registers r(2*addr[3:0]) as low and r(2*addr[3:0]+1) as high, SHALL return {high, low}, and SHALL ignore addr[4].
REQ-021 A byte index >= REG_COUNT SHALL read 8'h00 and SHALL be ignored on write; with REG_COUNT = 16, only r16..r31 are implemented, and indices 0..15 are the unimplemented ones.
REQ-022 A byte write SHALL update only rNN with rd[7:0]; a pair write SHALL update low with rd[7:0] and high with rd[15:8] on the same edge.
REQ-023 The pointer port SHALL write pd to the selected pair when pw = 1 and pa != 0; when pa = 0, pw SHALL have no effect.
REQ-024 When both ports write the same byte on the same edge, rd SHALL win for that byte; the port's other, non-colliding byte SHALL still be written.
REQ-025 ptr SHALL be the selected pair, or 16'h0000 when pa = 0.
REQ-026 With REGISTERED_OUTPUTS = "FALSE", reads SHALL be combinational.
REQ-027 With REGISTERED_OUTPUTS = "FALSE" and BYPASS = "TRUE", each read byte matching a byte being written this cycle SHALL return the write data (priority per REQ-024).
REQ-028 With BYPASS = "FALSE", reads SHALL return the pre-edge contents.
REQ-029 With REGISTERED_OUTPUTS = "TRUE", rs1/rs2/ptr SHALL present, one cycle later, the value selected by the address/mode sampled at the edge, including writes committed on that same edge.
REQ-030 The clear FSM SHALL have two states: CLEAR and RUN.
REQ-031 In CLEAR, one pair per cycle SHALL be zeroed via an internal counter running 0..REG_COUNT/2-1.
REQ-032 After the last pair is zeroed, the FSM SHALL move to RUN and ready SHALL rise on the following edge; CLEAR therefore takes REG_COUNT/2 cycles after reset release.
REQ-033 During CLEAR, all external writes SHALL be ignored and rs1/rs2/ptr SHALL read 16'h0000.
REQ-034 The register array SHALL NOT be asynchronously reset; only the FSM, the counter, ready and any output registers are.

Reset
REQ-035 While rst = 1, the FSM SHALL be in CLEAR with counter = 0, ready = 0, and registered outputs = 16'h0000.
REQ-036 Asserting rst at any time, including mid-CLEAR, SHALL restart the clear sequence from pair 0 after release.

Verification
REQ-037 Release rst, hold rdw = 1 writing r0 = 8'h55 -> ready rises after 16 cycles (REG_COUNT = 32); r0 reads 8'h00; every pair reads 16'h0000.
REQ-038 In RUN, pair write rda = 5'h0D, rd = 16'hBEEF, then byte reads r26 and r27 -> 16'h00EF and 16'h00BE; ptr with pa = 1 -> 16'hBEEF.
REQ-039 Same edge: rd pair write to Z = 16'h1234 and pw = 1 with pa = 3, pd = 16'hAAAA -> Z = 16'h1234.
REQ-040 Same edge: byte write r30 = 8'h77 and pw with pa = 3, pd = 16'h0102 -> Z = 16'h0177.
REQ-041 BYPASS = "TRUE": write r5 = 8'h9C while rs1a = 5 -> rs1 = 16'h009C in the same cycle; BYPASS = "FALSE" -> the old value.
REQ-042 REG_COUNT = 16: write r3 = 8'hFF then read r3 -> 16'h0000; assert rst mid-CLEAR (cycle 3) -> ready rises 8 cycles after the second release.
